// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file port controller.
package regfile_pkg;

   localparam int NREG = 16;
   localparam int W    = 16;
   localparam int AW   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic          ra_en;
      logic [AW-1:0] ra_addr;
      logic          rb_en;
      logic [AW-1:0] rb_addr;
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic [W-1:0]  wr_data;
   } req_t;

endpackage

// File: rtl/regfile_port_ctrl_onehot_dec.sv
// Gated binary-to-one-hot decoder used for the output enables and load strobes.
module onehot_dec #(
   parameter int AW   = 4,
   parameter int NREG = 16
) (
   input  logic            en,
   input  logic [AW-1:0]   addr,
   output logic [NREG-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Request sequencer for a 16-entry tri-state register file: reads on A/B, then
// an optional write, then a valid/ready response carrying the read operands.
//
//   state | meaning
//   IDLE  | ReqReady high, waiting to latch a request
//   READ  | output enables driven, buses sampled at the closing edge
//   WRITE | load strobe and write data driven for one cycle
//   RESP  | RspValid high, operands held until RspReady
module regfile_port_ctrl
   import regfile_pkg::*;
(
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            ReqValid,
   output logic            ReqReady,
   input  logic            RaEn,
   input  logic [AW-1:0]   RaAddr,
   input  logic            RbEn,
   input  logic [AW-1:0]   RbAddr,
   input  logic            WrEn,
   input  logic [AW-1:0]   WrAddr,
   input  logic [W-1:0]    WrData,
   output logic [NREG-1:0] Oae,
   output logic [NREG-1:0] Obe,
   output logic [NREG-1:0] Ld,
   output logic [W-1:0]    I,
   input  logic [W-1:0]    BusA,
   input  logic [W-1:0]    BusB,
   output logic            RspValid,
   input  logic            RspReady,
   output logic [W-1:0]    RdA,
   output logic [W-1:0]    RdB
);

   state_e       state_q, state_d;
   req_t         req_q, req_d;
   logic [W-1:0] rda_q, rda_d;
   logic [W-1:0] rdb_q, rdb_d;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rda_d   = rda_q;
      rdb_d   = rdb_q;
      case (state_q)
         IDLE: begin
            if (ReqValid) begin
               req_d = '{ra_en: RaEn, ra_addr: RaAddr, rb_en: RbEn, rb_addr: RbAddr,
                          wr_en: WrEn, wr_addr: WrAddr, wr_data: WrData};
               rda_d = '0;
               rdb_d = '0;
               if (RaEn || RbEn) state_d = READ;
               else if (WrEn)    state_d = WRITE;
               else              state_d = RESP;
            end
         end
         READ: begin
            rda_d   = req_q.ra_en ? BusA : '0;
            rdb_d   = req_q.rb_en ? BusB : '0;
            state_d = req_q.wr_en ? WRITE : RESP;
         end
         WRITE: state_d = RESP;
         RESP: begin
            if (RspReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         rda_q   <= '0;
         rdb_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rda_q   <= rda_d;
         rdb_q   <= rdb_d;
      end
   end

   // Enables come only from flopped state and addresses so they cannot glitch.
   onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_oae (
      .en     (state_q == READ && req_q.ra_en),
      .addr   (req_q.ra_addr),
      .onehot (Oae)
   );

   onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_obe (
      .en     (state_q == READ && req_q.rb_en),
      .addr   (req_q.rb_addr),
      .onehot (Obe)
   );

   onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_ld (
      .en     (state_q == WRITE && req_q.wr_en),
      .addr   (req_q.wr_addr),
      .onehot (Ld)
   );

   // Ready is masked by reset so nothing looks acceptable while Rst_n is low.
   assign ReqReady = Rst_n && (state_q == IDLE);
   assign RspValid = (state_q == RESP);
   assign I        = (state_q == WRITE) ? req_q.wr_data : '0;
   assign RdA      = rda_q;
   assign RdB      = rdb_q;

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Sequencing controller that sits on the far side of the processor's 16-entry register file, which is built from dual-output registers with tri-state A/B buses. It accepts one access request at a time (two optional reads, one optional write), drives the one-hot output enables and load strobes, samples the shared A/B buses, and returns the read operands through a valid/ready response. Reads always complete before the write, so a request that reads and writes the same register returns the old value.

## Interface
- NREG, 16: number of registers; enable/load vectors are NREG bits wide.
- W, 16: data width of the register file buses.
- AW, 4: address width, equal to log2(NREG).

- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset; synchronous, active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request; high only in IDLE.
- RaEn / RaAddr  in  1 / AW  read on bus A enable and register index.
- RbEn / RbAddr  in  1 / AW  read on bus B enable and register index.
- WrEn / WrAddr / WrData  in  1 / AW / W  write enable, register index and data.
- Oae  out  NREG  one-hot A-bus output enables to the registers.
- Obe  out  NREG  one-hot B-bus output enables to the registers.
- Ld  out  NREG  one-hot load strobes to the registers.
- I  out  W  shared write-data bus to the register inputs.
- BusA / BusB  in  W  tri-state read buses from the registers.
- RspValid  out  1  response valid.
- RspReady  in  1  consumer accepts the response.
- RdA / RdB  out  W  read results.

## Operation
- The FSM has four states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - ReqReady=1.
  - On ReqValid&&ReqReady, latch all request fields.
  - Next state: READ if RaEn||RbEn; else WRITE if WrEn; else RESP.
- **READ** (exactly 1 cycle)
  - Oae=onehot(RaAddr) if RaEn, else 0.
  - Obe=onehot(RbAddr) if RbEn, else 0.
  - At the closing edge, RdA<=BusA if RaEn, else 0; RdB likewise.
  - Next state: WRITE if WrEn, else RESP.
- **WRITE** (exactly 1 cycle)
  - Ld=onehot(WrAddr) and I=latched WrData.
  - The register loads at the closing edge.
  - Next state: RESP.
- **RESP**
  - RspValid=1; RdA/RdB are held stable.
  - Leave to IDLE on RspReady.
  - A request with no reads and no write still passes through RESP, with RdA=RdB=0.
- **Output invariants**
  - At most one bit set in each of Oae, Obe and Ld.
  - Oae/Obe are never nonzero in the same cycle as Ld.
  - Outside WRITE, I=0.
- **Enable and data rules**
  - Oae/Obe/Ld are decoded from flopped state and flopped addresses only, so they are glitch-free.
  - RaAddr=RbAddr with both enabled is legal: both buses are driven by the same register.
  - No arithmetic; all data passes through unmodified at W bits.
- **Reset**
  - While Rst_n=0 at an edge: state<=IDLE, latched request cleared, RdA=RdB=0.
  - During reset, ReqReady=0 and RspValid=0; Oae=Obe=Ld=0 and I=0.
  - Reset mid-operation abandons the request: no Ld pulse follows and no response is issued.
- Request inputs are ignored outside IDLE.

## Timing
- **Handshake**
  - The request is accepted at the edge where ReqValid&&ReqReady.
  - Inputs may change freely after acceptance.
- **Latency from the accept edge to RspValid high**
  - Read+write: 3 cycles.
  - Read-only or write-only: 2 cycles.
  - Neither: 1 cycle.
- **Bus sampling**
  - BusA/BusB are sampled at the edge that ends READ.
  - Register outputs settle within the same cycle.
- **Write visibility**
  - A write becomes visible on the buses from the cycle after WRITE.
- **Throughput**
  - Back-to-back throughput with RspReady held high is one request per latency+1 cycles.
  - IDLE always lasts at least 1 cycle, so there is no accept in the RESP exit cycle.

## Structure
- Package regfile_pkg holds:
  - the state enum {IDLE, READ, WRITE, RESP};
  - the defaults NREG=16, W=16, AW=4;
  - the request record typedef (enables, addresses, data).
- Sub-module onehot_dec (AW in, NREG out, enable input gates the output to zero) is instantiated three times: Oae, Obe, Ld.
- The FSM, request latch and result registers stay in the top module.

## Test plan
- **Reset**: hold Rst_n=0 for 3 cycles while ReqValid=1 -> ReqReady=0, RspValid=0, Oae=Obe=Ld=0, RdA=RdB=0 throughout; ReqReady=1 in the first cycle after release.
- **Write then read**
  - Write 16'hBEEF to r5 -> Ld=16'h0020 for exactly 1 cycle with I=16'hBEEF.
  - Then read A=r5, B=r0 (r0 reset to 0) -> Oae=16'h0020, Obe=16'h0001, RdA=16'hBEEF, RdB=16'h0000; RspValid 2 cycles after the accept edge.
- **Read-before-write**: r3=16'h1111; request read A=r3 and write r3=16'h2222 -> RdA=16'h1111; a subsequent read of r3 returns 16'h2222.
- **Dual read of same register**: r9=16'hA5A5; RaEn=RbEn=1, both addresses 9 -> Oae=Obe=16'h0200 in the same cycle; RdA=RdB=16'hA5A5.
- **Response backpressure**: RspReady=0 for 4 cycles -> RspValid stays 1, RdA/RdB unchanged, ReqReady=0; the FSM returns to IDLE one cycle after RspReady=1.
- **Reset mid-operation**: assert Rst_n=0 in the READ cycle of a read+write to r7 -> Ld never pulses, RspValid never asserts, and r7 keeps its prior value.
